uart_baud_gen: RTL and testbench
================================

// Module: uart_baud_gen
// PURPOSE
//  Fractional baud-rate generator with hardware auto-baud for the UART. Drives the
//  16x oversample sample_tick into the RX path and the 1x tx_tick into the TX path.
//  Runs entirely in the uart_clk domain. Divisor config arrives already
//  synchronised from the register file.
// PARAMETERS
//  DIV_WIDTH      16  integer divisor width (uart_clk cycles per sample_tick)
//  FRAC_WIDTH     4   fractional divisor width (units of 1/2^FRAC_WIDTH cycle)
//  RESET_DIV_INT  27  active integer divisor after reset (50 MHz, 115200 baud)
//  RESET_DIV_FRAC 2   active fractional divisor after reset
// PORTS
//  uart_clk        in   1               UART clock
//  uart_rst_n      in   1               async active-low reset
//  enable          in   1               tick generation enable
//  cfg_div_int     in   DIV_WIDTH       programmed integer divisor
//  cfg_div_frac    in   FRAC_WIDTH      programmed fractional divisor
//  cfg_load        in   1               pulse: capture cfg_div_* into shadow
//  rx_serial_sync  in   1               synchronised RX line (idle high)
//  autobaud_start  in   1               pulse: begin auto-baud measurement
//  sample_tick     out  1               1-cycle pulse at 16x baud
//  tx_tick         out  1               1-cycle pulse at 1x baud (every 16th sample_tick)
//  autobaud_busy   out  1               measurement in progress
//  autobaud_done   out  1               1-cycle pulse: measurement succeeded
//  autobaud_err    out  1               sticky, cleared by next autobaud_start
//  active_div_int  out  DIV_WIDTH       divisor currently in use
//  active_div_frac out  FRAC_WIDTH      fraction currently in use
// BEHAVIOUR
//  Reset: uart_rst_n is asynchronous, active-low; clock is uart_clk.
//  - Reset values: all pulse/flag outputs 0; active_div = RESET_DIV_INT/FRAC.
//  - Reset clears the down-counter, frac accumulator, 4-bit sub-counter and FSM.
//  - Reset mid-measurement aborts it with no done/err pulse.
//  Period: each tick period N = active_div_int + carry.
//  - carry = overflow of frac_acc += active_div_frac (mod 2^FRAC_WIDTH), evaluated per period.
//  - sample_tick is registered, high exactly 1 cycle every N cycles.
//  - First tick comes N cycles after the enable 0->1 edge.
//  - active_div_int == 0: no ticks. div_int == 1 with frac 0: tick every cycle.
//  tx_tick: sub-counter increments on each sample_tick.
//  - tx_tick fires in the same cycle as the sample_tick that moves sub-counter 15->0.
//  enable == 0: both counters held at reload/0, frac_acc = 0, no ticks.
//  Config: cfg_load captures cfg_div_* into a shadow register.
//  - Shadow moves into active at the next period reload, so no short or long period occurs.
//  - Transfer is immediate if enable == 0.
//  - Another cfg_load before transfer overwrites the shadow.
//  Auto-baud FSM: IDLE -> WAIT_IDLE -> WAIT_FALL -> MEASURE -> IDLE.
//  - IDLE: autobaud_start -> WAIT_IDLE, clears err, sets busy. Start while busy is ignored.
//  - WAIT_IDLE: line high for 1 cycle -> WAIT_FALL.
//  - WAIT_FALL: falling edge -> MEASURE, cnt = 1.
//  - MEASURE: cnt++ each low cycle. Rising edge -> IDLE.
//  - Measurement char must have LSB = 1 (e.g. 0x55), so the low pulse is exactly one bit time.
//  - Result (cnt is DIV_WIDTH+FRAC_WIDTH bits): active_div_int = cnt >> 4; active_div_frac
//    = cnt[3:0] << (FRAC_WIDTH-4). Pulse done; counters restart phase from 0.
//  - Error: cnt < 16 at the edge, or cnt saturates while low -> err = 1, active_div unchanged.
//  - busy drops in the cycle done/err is set.
//  Precedence: an auto-baud result beats a pending shadow, and the pending shadow is discarded.
//  - cfg_load in the same cycle as done: the cfg_load wins and is applied at the next reload.
// TESTING
//  1 Reset, enable=1, default 27/2 -> 16 ticks span 434 cycles (14 periods of 27, 2 of 28);
//    tx_tick on ticks 16, 32.
//  2 div_int=4 frac=0 -> sample_tick every 4 cycles; tx_tick every 64 cycles; first tick 4 cycles after enable.
//  3 cfg_load 10/0 mid-period with active 27/0 -> current period still 27 cycles, then 10.
//  4 Auto-baud: line low 868 cycles -> done pulse; active_div = 54 int, frac 4; busy low same cycle.
//  5 Auto-baud glitch: low for 9 cycles -> autobaud_err = 1, active_div unchanged, no done.
//  6 enable=0 mid-stream, div_int=0, reset during MEASURE -> no ticks; FSM IDLE; outputs at reset values.

Source files
------------

// File: rtl/uart_baud_gen_if.sv
// Config/status bundle between the UART register file / RX-TX paths and the baud generator.
interface uart_baud_gen_if #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
);
    logic                  enable;
    logic [DIV_WIDTH-1:0]  cfg_div_int;
    logic [FRAC_WIDTH-1:0] cfg_div_frac;
    logic                  cfg_load;
    logic                  rx_serial_sync;
    logic                  autobaud_start;
    logic                  sample_tick;
    logic                  tx_tick;
    logic                  autobaud_busy;
    logic                  autobaud_done;
    logic                  autobaud_err;
    logic [DIV_WIDTH-1:0]  active_div_int;
    logic [FRAC_WIDTH-1:0] active_div_frac;

    modport master (
        output enable, cfg_div_int, cfg_div_frac, cfg_load, rx_serial_sync, autobaud_start,
        input  sample_tick, tx_tick, autobaud_busy, autobaud_done, autobaud_err,
               active_div_int, active_div_frac
    );

    modport slave (
        input  enable, cfg_div_int, cfg_div_frac, cfg_load, rx_serial_sync, autobaud_start,
        output sample_tick, tx_tick, autobaud_busy, autobaud_done, autobaud_err,
               active_div_int, active_div_frac
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud generator: 16x sample_tick, 1x tx_tick, and hardware auto-baud
// measurement of one low bit time on the synchronised RX line.
module uart_baud_gen #(
    parameter int DIV_WIDTH      = 16,
    parameter int FRAC_WIDTH     = 4,
    parameter int RESET_DIV_INT  = 27,
    parameter int RESET_DIV_FRAC = 2
) (
    input  logic           uart_clk,
    input  logic           uart_rst_n,
    uart_baud_gen_if.slave bus
);
    localparam int CW = DIV_WIDTH + FRAC_WIDTH;

    typedef enum logic [1:0] {
        AB_IDLE,
        AB_WAIT_IDLE,
        AB_WAIT_FALL,
        AB_MEASURE
    } ab_state_e;

    ab_state_e             state_q, state_d;
    logic [DIV_WIDTH-1:0]  per_cnt_q, per_cnt_d;
    logic [FRAC_WIDTH-1:0] frac_acc_q, frac_acc_d;
    logic [3:0]            sub_q, sub_d;
    logic                  tick_q, tick_d;
    logic                  tx_q, tx_d;
    logic [DIV_WIDTH-1:0]  act_int_q, act_int_d;
    logic [FRAC_WIDTH-1:0] act_frac_q, act_frac_d;
    logic [DIV_WIDTH-1:0]  shd_int_q, shd_int_d;
    logic [FRAC_WIDTH-1:0] shd_frac_q, shd_frac_d;
    logic                  pend_q, pend_d;
    logic [CW-1:0]         ab_cnt_q, ab_cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  run;
    logic                  reload;
    logic [FRAC_WIDTH:0]   acc_sum;
    logic [DIV_WIDTH:0]    period_m1;

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state_q    <= AB_IDLE;
            per_cnt_q  <= '0;
            frac_acc_q <= '0;
            sub_q      <= '0;
            tick_q     <= 1'b0;
            tx_q       <= 1'b0;
            act_int_q  <= DIV_WIDTH'(RESET_DIV_INT);
            act_frac_q <= FRAC_WIDTH'(RESET_DIV_FRAC);
            shd_int_q  <= '0;
            shd_frac_q <= '0;
            pend_q     <= 1'b0;
            ab_cnt_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            frac_acc_q <= frac_acc_d;
            sub_q      <= sub_d;
            tick_q     <= tick_d;
            tx_q       <= tx_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
            ab_cnt_q   <= ab_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Period length is div_int plus the carry this period's fractional step produces.
    assign run       = bus.enable && (act_int_q != '0);
    assign acc_sum   = {1'b0, frac_acc_q} + {1'b0, act_frac_q};
    assign period_m1 = {1'b0, act_int_q} + {{DIV_WIDTH{1'b0}}, acc_sum[FRAC_WIDTH]}
                       - (DIV_WIDTH+1)'(1);
    assign reload    = run && ({1'b0, per_cnt_q} == period_m1);

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        frac_acc_d = frac_acc_q;
        sub_d      = sub_q;
        tick_d     = 1'b0;
        tx_d       = 1'b0;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;
        ab_cnt_d   = ab_cnt_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (!run) begin
            per_cnt_d  = '0;
            frac_acc_d = '0;
            sub_d      = '0;
        end else if (reload) begin
            per_cnt_d  = '0;
            frac_acc_d = acc_sum[FRAC_WIDTH-1:0];
            tick_d     = 1'b1;
            tx_d       = (sub_q == 4'hF);
            sub_d      = sub_q + 4'd1;
        end else begin
            per_cnt_d  = per_cnt_q + DIV_WIDTH'(1);
        end

        // Shadow only lands on a period boundary, or at once while no period is running.
        if (pend_q && (!run || reload)) begin
            act_int_d  = shd_int_q;
            act_frac_d = shd_frac_q;
            pend_d     = 1'b0;
        end

        case (state_q)
            AB_IDLE: begin
                if (bus.autobaud_start) begin
                    state_d = AB_WAIT_IDLE;
                    err_d   = 1'b0;
                end
            end
            AB_WAIT_IDLE: begin
                if (bus.rx_serial_sync) state_d = AB_WAIT_FALL;
            end
            AB_WAIT_FALL: begin
                if (!bus.rx_serial_sync) begin
                    state_d  = AB_MEASURE;
                    ab_cnt_d = CW'(1);
                end
            end
            AB_MEASURE: begin
                if (bus.rx_serial_sync) begin
                    state_d = AB_IDLE;
                    if (ab_cnt_q < CW'(16)) begin
                        err_d = 1'b1;
                    end else begin
                        // Result overrides any pending shadow and restarts tick phase.
                        done_d     = 1'b1;
                        act_int_d  = DIV_WIDTH'(ab_cnt_q >> 4);
                        act_frac_d = FRAC_WIDTH'(ab_cnt_q[3:0]) << (FRAC_WIDTH - 4);
                        pend_d     = 1'b0;
                        per_cnt_d  = '0;
                        frac_acc_d = '0;
                        sub_d      = '0;
                        tick_d     = 1'b0;
                        tx_d       = 1'b0;
                    end
                end else if (&ab_cnt_q) begin
                    state_d = AB_IDLE;
                    err_d   = 1'b1;
                end else begin
                    ab_cnt_d = ab_cnt_q + CW'(1);
                end
            end
            default: state_d = AB_IDLE;
        endcase

        if (bus.cfg_load) begin
            shd_int_d  = bus.cfg_div_int;
            shd_frac_d = bus.cfg_div_frac;
            pend_d     = 1'b1;
        end
    end

    assign bus.sample_tick     = tick_q;
    assign bus.tx_tick         = tx_q;
    assign bus.autobaud_busy   = (state_q != AB_IDLE);
    assign bus.autobaud_done   = done_q;
    assign bus.autobaud_err    = err_q;
    assign bus.active_div_int  = act_int_q;
    assign bus.active_div_frac = act_frac_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: per-cycle compare against a schedule-based model plus directed literal checks.
module tb_uart_baud_gen;
    localparam int DW = 16;
    localparam int FW = 4;
    localparam int FR = 1 << FW;
    localparam int AB_MAX = (1 << (DW + FW)) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    uart_baud_gen_if #(.DIV_WIDTH(DW), .FRAC_WIDTH(FW)) bus ();

    uart_baud_gen #(
        .DIV_WIDTH(DW), .FRAC_WIDTH(FW), .RESET_DIV_INT(27), .RESET_DIV_FRAC(2)
    ) dut (
        .uart_clk  (clk),
        .uart_rst_n(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            if (nerr <= 40) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Model state: ticks are scheduled as absolute edge numbers, carries from the running fraction sum.
    int cyc, m_int, m_frac, m_sh_int, m_sh_frac, m_ticks, m_total, m_due, ab_low;
    bit m_pend, m_run, ab_arm, ab_hi;
    bit exp_tick, exp_tx, exp_busy, exp_done, exp_err;

    function automatic int period_len();
        return m_int + ((m_total + m_frac) / FR - m_total / FR);
    endfunction

    task automatic model_step();
        bit run;
        if (!rst_n) begin
            cyc = 0; m_int = 27; m_frac = 2; m_pend = 0; m_run = 0; m_ticks = 0;
            m_total = 0; m_due = 0; ab_arm = 0; ab_hi = 0; ab_low = 0;
            exp_tick = 0; exp_tx = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
            return;
        end
        cyc++;
        exp_tick = 0; exp_tx = 0; exp_done = 0;
        run = bus.enable && (m_int != 0);
        if (!run) begin
            m_run = 0; m_ticks = 0; m_total = 0;
            if (m_pend) begin m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; end
        end else begin
            if (!m_run) begin m_run = 1; m_due = cyc + period_len() - 1; end
            if (cyc == m_due) begin
                m_ticks++;
                exp_tick = 1;
                exp_tx = (m_ticks % 16 == 0);
                m_total += m_frac;
                if (m_pend) begin m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; end
                m_due = cyc + period_len();
            end
        end
        if (!ab_arm) begin
            if (bus.autobaud_start) begin ab_arm = 1; ab_hi = 0; ab_low = 0; exp_err = 0; end
        end else if (!ab_hi) begin
            ab_hi = bus.rx_serial_sync;
        end else if (ab_low == 0) begin
            if (!bus.rx_serial_sync) ab_low = 1;
        end else if (bus.rx_serial_sync) begin
            ab_arm = 0;
            if (ab_low < 16) exp_err = 1;
            else begin
                exp_done = 1; m_int = ab_low / 16; m_frac = ab_low % 16;
                m_pend = 0; m_run = 0; m_ticks = 0; m_total = 0; exp_tick = 0; exp_tx = 0;
            end
        end else if (ab_low >= AB_MAX) begin
            ab_arm = 0; exp_err = 1;
        end else begin
            ab_low++;
        end
        exp_busy = ab_arm;
        if (bus.cfg_load) begin
            m_sh_int = int'(bus.cfg_div_int); m_sh_frac = int'(bus.cfg_div_frac); m_pend = 1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    always @(negedge clk) begin
        chk("cyc_sample_tick", bus.sample_tick, exp_tick);
        chk("cyc_tx_tick", bus.tx_tick, exp_tx);
        chk("cyc_busy", bus.autobaud_busy, exp_busy);
        chk("cyc_done", bus.autobaud_done, exp_done);
        chk("cyc_err", bus.autobaud_err, exp_err);
        chk("cyc_div_int", bus.active_div_int, m_int);
        chk("cyc_div_frac", bus.active_div_frac, m_frac);
    end

    int tk_q[$];
    int tx_q[$];

    // Steps n cycles recording the cycle index of each tick; optional cfg_load pulse at cycle ld_k.
    task automatic watch(input int n, input int ld_k, input int ld_int, input int ld_frac);
        tk_q.delete();
        tx_q.delete();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.sample_tick) tk_q.push_back(k);
            if (bus.tx_tick) tx_q.push_back(k);
            if (k == ld_k) begin
                bus.cfg_div_int = DW'(ld_int); bus.cfg_div_frac = FW'(ld_frac); bus.cfg_load = 1'b1;
            end else begin
                bus.cfg_load = 1'b0;
            end
        end
    endtask

    task automatic load_cfg(input int di, input int df);
        bus.cfg_div_int = DW'(di); bus.cfg_div_frac = FW'(df); bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ab_start();
        bus.autobaud_start = 1'b1;
        @(negedge clk);
        bus.autobaud_start = 1'b0;
    endtask

    bit found, done_seen;

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.cfg_div_int = '0; bus.cfg_div_frac = '0; bus.cfg_load = 1'b0;
        bus.rx_serial_sync = 1'b1; bus.autobaud_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick", bus.sample_tick, 0);
        chk("rst_busy", bus.autobaud_busy, 0);
        chk("rst_err", bus.autobaud_err, 0);
        chk("rst_div_int", bus.active_div_int, 27);
        chk("rst_div_frac", bus.active_div_frac, 2);
        #2 rst_n = 1'b1;

        // Default 27/2: 16 ticks span 434 cycles, tx on ticks 16 and 32.
        @(negedge clk);
        bus.enable = 1'b1;
        watch(870, -1, 0, 0);
        chk("t1_ntick", tk_q.size(), 32);
        chk("t1_first", tk_q[0], 27);
        chk("t1_long_period", tk_q[7] - tk_q[6], 28);
        chk("t1_tick16", tk_q[15], 434);
        chk("t1_ntx", tx_q.size(), 2);
        chk("t1_tx0", tx_q[0], 434);
        chk("t1_tx1", tx_q[1], 868);

        // div 4/0: immediate transfer while disabled, tick every 4, tx every 64.
        bus.enable = 1'b0;
        load_cfg(4, 0);
        chk("t2_div_int", bus.active_div_int, 4);
        bus.enable = 1'b1;
        watch(128, -1, 0, 0);
        chk("t2_first", tk_q[0], 4);
        chk("t2_ntick", tk_q.size(), 32);
        chk("t2_ntx", tx_q.size(), 2);
        chk("t2_tx0", tx_q[0], 64);
        chk("t2_tx1", tx_q[1], 128);

        // Mid-period cfg_load 10/0 with active 27/0: period stays 27, then 10.
        bus.enable = 1'b0;
        load_cfg(27, 0);
        chk("t3_div_frac", bus.active_div_frac, 0);
        bus.enable = 1'b1;
        watch(50, 5, 10, 0);
        chk("t3_first", tk_q[0], 27);
        chk("t3_second", tk_q[1], 37);
        chk("t3_third", tk_q[2], 47);
        chk("t3_div_int", bus.active_div_int, 10);

        // Auto-baud: 868 low cycles -> 54 int, 4 frac.
        ab_start();
        chk("t4_busy", bus.autobaud_busy, 1);
        repeat (3) @(negedge clk);
        bus.rx_serial_sync = 1'b0;
        repeat (868) @(negedge clk);
        bus.rx_serial_sync = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.autobaud_done) begin
                found = 1;
                chk("t4_busy_at_done", bus.autobaud_busy, 0);
                chk("t4_div_int", bus.active_div_int, 54);
                chk("t4_div_frac", bus.active_div_frac, 4);
            end
        end
        chk("t4_done_seen", found, 1);
        watch(60, -1, 0, 0);
        chk("t4_restart_first", tk_q[0], 54);

        // Glitch: 9 low cycles -> err, no done, divisor unchanged.
        ab_start();
        repeat (3) @(negedge clk);
        bus.rx_serial_sync = 1'b0;
        repeat (9) @(negedge clk);
        bus.rx_serial_sync = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.autobaud_done) done_seen = 1;
        end
        chk("t5_err", bus.autobaud_err, 1);
        chk("t5_no_done", done_seen, 0);
        chk("t5_busy", bus.autobaud_busy, 0);
        chk("t5_div_int", bus.active_div_int, 54);
        chk("t5_div_frac", bus.active_div_frac, 4);

        // enable=0, div_int=0, reset during MEASURE.
        bus.enable = 1'b0;
        watch(100, -1, 0, 0);
        chk("t6_disabled_ticks", tk_q.size(), 0);
        load_cfg(0, 0);
        chk("t6_div_zero", bus.active_div_int, 0);
        bus.enable = 1'b1;
        watch(100, -1, 0, 0);
        chk("t6_div0_ticks", tk_q.size(), 0);
        ab_start();
        chk("t6_err_cleared", bus.autobaud_err, 0);
        repeat (2) @(negedge clk);
        bus.rx_serial_sync = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_busy_measure", bus.autobaud_busy, 1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", bus.autobaud_busy, 0);
        chk("t6_rst_done", bus.autobaud_done, 0);
        chk("t6_rst_tick", bus.sample_tick, 0);
        chk("t6_rst_div_int", bus.active_div_int, 27);
        chk("t6_rst_div_frac", bus.active_div_frac, 2);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.autobaud_done || bus.autobaud_err) done_seen = 1;
        end
        chk("t6_no_pulse_after_abort", done_seen, 0);
        chk("t6_idle_after_abort", bus.autobaud_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
